riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//   Shares the single-port data memory between the CPU load/store path and the UART programmer (upg).
//   Grants one requester per cycle and returns registered read data to the owner one cycle later.
//   Supports an upg exclusive lock for bulk programming, with a timeout.
//   Sits between riscv_io_bridge/uart_bmpg_0 and the data-memory block RAM.
// PARAMETERS
//   ADDR_W       14      word-address width of the memory port
//   STARVE_MAX   8       consecutive denied cpu cycles before a forced cpu grant (guard build only)
//   LOCK_TIMEOUT 65535   max cycles the lock is held without any upg_req before forced release
// PORTS
//   clk          in   1       system clock
//   rst          in   1       synchronous active-high reset
//   cpu_req      in   1       cpu access request, held until cpu_gnt
//   cpu_we       in   1       1=write, 0=read
//   cpu_addr     in   ADDR_W  cpu word address
//   cpu_wdata    in   32      cpu write data
//   cpu_be       in   4       cpu byte enables (writes only)
//   cpu_gnt      out  1       cpu request accepted this cycle (combinational)
//   cpu_rvalid   out  1       cpu_rdata valid (registered)
//   cpu_rdata    out  32      cpu read data
//   upg_req/upg_we/upg_addr/upg_wdata/upg_be  in  same widths as the cpu_* signals, for the upg requester
//   upg_lock     in   1       request exclusive ownership
//   upg_gnt      out  1       upg request accepted this cycle
//   upg_rvalid   out  1       upg_rdata valid
//   upg_rdata    out  32      upg read data
//   mem_en       out  1       memory access strobe
//   mem_we       out  4       per-byte write strobe (be & we)
//   mem_addr     out  ADDR_W  memory address
//   mem_wdata    out  32      memory write data
//   mem_rdata    in   32      memory read data, valid 1 cycle after mem_en with mem_we==0
//   locked       out  1       FSM in S_LOCK
// BEHAVIOUR
//   FSM states: S_ARB, S_DRAIN, S_LOCK. Reset -> S_ARB.
//   Reset values: all gnt/rvalid/mem_en/locked = 0; mem_we = 0; rdata outputs = 0; counters = 0.
//   S_ARB: fixed priority, upg over cpu; at most one gnt per cycle.
//     The granted request drives mem_* in the same cycle.
//   Read return: on a granted read, the owner tag is registered.
//     Next cycle: <owner>_rvalid=1 and <owner>_rdata=mem_rdata.
//     Back-to-back reads are allowed: one per cycle, latency 1, in order.
//   Write: mem_we = be when gnt & we. No response; gnt is the acknowledgement.
//   upg_lock=1 in S_ARB:
//     If a read is outstanding -> S_DRAIN, otherwise -> S_LOCK next cycle.
//     The lock request is still served under ARB rules in the request cycle.
//   S_DRAIN: no grants; completes the pending read return; -> S_LOCK.
//   S_LOCK: cpu_gnt=0 always; upg_req is granted every cycle.
//     upg_lock=0 -> S_ARB next cycle.
//   Lock timeout: idle counter increments each S_LOCK cycle with upg_req=0; cleared on upg_req.
//     Reaching LOCK_TIMEOUT -> S_ARB; lock is re-honoured only after upg_lock deasserts then reasserts.
//   Simultaneous cpu_req & upg_req in S_ARB: upg wins; cpu holds its request.
//   rst asserted mid-operation: FSM and counters return to reset values on that edge.
//     A pending rvalid is dropped. cpu_req must be re-issued.
//   Address/data widths: no translation; addr passed through unmodified.
// CONFIGURATION
//   ARB_STARVE_GUARD_EN defined:
//     A starve counter counts consecutive S_ARB cycles with cpu_req=1 & cpu_gnt=0.
//     At STARVE_MAX the next S_ARB cycle grants cpu over upg, then the counter clears.
//     The counter is frozen in S_DRAIN/S_LOCK.
//   ARB_STARVE_GUARD_EN undefined: strict upg priority; counter logic absent.
// TESTING
//   - cpu read alone at addr 0x010, mem holds 0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid=1, cpu_rdata=0xDEADBEEF next cycle.
//   - cpu_req & upg_req same cycle -> upg_gnt=1, cpu_gnt=0; cpu granted the cycle after upg drops.
//   - upg_lock=1 while a cpu read is pending:
//     -> one S_DRAIN cycle delivers cpu_rvalid; locked=1 next; cpu_req then never granted until upg_lock=0.
//   - LOCK_TIMEOUT=16, locked with upg_req=0 for 16 cycles -> locked=0, cpu_req granted the following cycle.
//   - Guard build, STARVE_MAX=8, upg_req and cpu_req held high -> cpu_gnt pulses once every 9th cycle.
//     Non-guard build -> cpu_gnt never asserts.
//   - rst pulsed the cycle after a granted upg read -> upg_rvalid stays 0, state S_ARB, locked=0.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//   Shares the single-port data memory between the CPU load/store path and
//   the UART programmer (upg). One requester is granted per cycle; read data
//   comes back to the owner one cycle after the grant. The upg side can take
//   exclusive ownership (lock) for bulk programming. An idle timeout releases
//   a lock that is held without traffic.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, a starvation guard forces a cpu grant after STARVE_MAX
//   consecutive denied cpu cycles in arbitration. When undefined, upg has
//   strict priority and the guard logic is not built.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/be cpu request channel (held until cpu_gnt)
//   cpu_gnt                  cpu request accepted this cycle (combinational)
//   cpu_rvalid, cpu_rdata    cpu read return, one cycle after the grant
//   upg_req/we/addr/wdata/be upg request channel
//   upg_lock                 upg request for exclusive ownership
//   upg_gnt                  upg request accepted this cycle (combinational)
//   upg_rvalid, upg_rdata    upg read return, one cycle after the grant
//   mem_en/we/addr/wdata     memory request, driven by the granted requester
//   mem_rdata                memory read data, valid one cycle after a read
//   locked                   arbiter is in the exclusive-lock state
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_MAX   = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              upg_req,
    input  logic              upg_we,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [31:0]       upg_wdata,
    input  logic [3:0]        upg_be,
    input  logic              upg_lock,
    output logic              upg_gnt,
    output logic              upg_rvalid,
    output logic [31:0]       upg_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              locked
);

    typedef enum logic [1:0] {S_ARB, S_DRAIN, S_LOCK} state_t;

    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              lock_block;   // set by a timeout; cleared once upg_lock drops
    logic              cpu_rvalid_p1;
    logic              upg_rvalid_p1;
    logic              rd_issue_p0;
    logic              force_cpu;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_cnt;

    assign force_cpu = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Counts consecutive denied cpu cycles in arbitration; frozen elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == S_ARB) begin
            if (cpu_gnt || !cpu_req)
                starve_cnt <= '0;
            else if (!force_cpu)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    // ---- stage p0: request arbitration and memory drive ----
    always_comb begin
        cpu_gnt = 1'b0;
        upg_gnt = 1'b0;
        if (!rst) begin
            case (state)
                S_ARB: begin
                    if (force_cpu && cpu_req)
                        cpu_gnt = 1'b1;
                    else if (upg_req)
                        upg_gnt = 1'b1;
                    else
                        cpu_gnt = cpu_req;
                end
                S_LOCK:  upg_gnt = upg_req;
                default: ;
            endcase
        end
    end

    assign mem_en      = cpu_gnt | upg_gnt;
    assign mem_addr    = upg_gnt ? upg_addr : cpu_addr;
    assign mem_wdata   = upg_gnt ? upg_wdata : cpu_wdata;
    assign mem_we      = upg_gnt ? (upg_be & {4{upg_we}}) :
                         cpu_gnt ? (cpu_be & {4{cpu_we}}) : 4'b0000;
    assign rd_issue_p0 = (upg_gnt & ~upg_we) | (cpu_gnt & ~cpu_we);

    // ---- stage p1: read return, owner selected by the registered tag ----
    assign cpu_rvalid = cpu_rvalid_p1;
    assign upg_rvalid = upg_rvalid_p1;
    assign cpu_rdata  = cpu_rvalid_p1 ? mem_rdata : 32'h0;
    assign upg_rdata  = upg_rvalid_p1 ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_ARB;
            locked        <= 1'b0;
            idle_cnt      <= '0;
            lock_block    <= 1'b0;
            cpu_rvalid_p1 <= 1'b0;
            upg_rvalid_p1 <= 1'b0;
        end else begin
            cpu_rvalid_p1 <= cpu_gnt & ~cpu_we;
            upg_rvalid_p1 <= upg_gnt & ~upg_we;
            if (!upg_lock)
                lock_block <= 1'b0;
            case (state)
                S_ARB: begin
                    // A read granted this cycle must return before locking.
                    if (upg_lock && !lock_block) begin
                        state  <= rd_issue_p0 ? S_DRAIN : S_LOCK;
                        locked <= ~rd_issue_p0;
                    end
                end
                S_DRAIN: begin
                    state  <= S_LOCK;
                    locked <= 1'b1;
                end
                S_LOCK: begin
                    if (!upg_lock) begin
                        state    <= S_ARB;
                        locked   <= 1'b0;
                        idle_cnt <= '0;
                    end else if (upg_req) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state      <= S_ARB;
                        locked     <= 1'b0;
                        idle_cnt   <= '0;
                        lock_block <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_ARB;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
